// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings plus the iteration-counter width helper.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mdu_state_e;

    // Counter must hold values 0..width, hence width+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it did not go negative.
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem[WIDTH-1:0], dividend_msb};
    assign diff    = shifted - {1'b0, divisor};

    // A set top remainder bit means the shifted value exceeds any WIDTH-bit divisor.
    assign q_bit    = rem[WIDTH] | (shifted >= {1'b0, divisor});
    assign rem_next = q_bit ? diff : shifted;

endmodule

// File: rtl/mdu_iter.sv
// WIDTH-generic iterative MIPS mult/multu/div/divu engine returning {hi, lo}.
// Build option: define MDU_EARLY_OUT_EN to end multiply CALC once the multiplier is exhausted.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic               busy_o,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               div_by_zero_o,
    output mdu_state_e         state_dbg
);

    // Handshake: start_i is a level request taken only in IDLE when annul_i is low;
    // ready_o is a one-cycle completion strobe with no backpressure.

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    mdu_state_e state, state_nxt;

    logic                 is_div_q;
    logic                 neg_a;
    logic                 neg_b;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH:0]       rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     dvsr;
    logic [2*WIDTH-1:0]   result_q;
    logic                 dbz_q;

    logic                 in_signed;
    logic                 in_div;
    logic                 in_neg_a;
    logic                 in_neg_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 in_zero_div;
    logic                 accept;

    logic                 calc_last;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH:0]       rem_nxt;
    logic                 q_bit;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [2*WIDTH-1:0]   fix_result;

    // Operand decode at the request boundary; signs are latched, magnitudes iterated.
    assign in_signed   = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    assign in_div      = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    assign in_neg_a    = in_signed & opdata1_i[WIDTH-1];
    assign in_neg_b    = in_signed & opdata2_i[WIDTH-1];
    assign mag_a       = in_neg_a ? (~opdata1_i + 1'b1) : opdata1_i;
    assign mag_b       = in_neg_b ? (~opdata2_i + 1'b1) : opdata2_i;
    assign in_zero_div = in_div && (opdata2_i == '0);
    assign accept      = (state == IDLE) && start_i && !annul_i;

`ifdef MDU_EARLY_OUT_EN
    assign calc_last = (cnt == LAST) || (!is_div_q && (mplier[WIDTH-1:1] == '0));
`else
    assign calc_last = (cnt == LAST);
`endif

    // Shift-add multiply step, multiplier LSB first.
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem          (rem),
        .dividend_msb (quo[WIDTH-1]),
        .divisor      (dvsr),
        .rem_next     (rem_nxt),
        .q_bit        (q_bit)
    );

    // Remainder follows the dividend sign; quotient/product follow sign difference.
    assign prod_fix   = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
    assign quo_fix    = (neg_a ^ neg_b) ? (~quo + 1'b1) : quo;
    assign rem_fix    = neg_a ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
    assign fix_result = is_div_q ? {rem_fix, quo_fix} : prod_fix;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = in_zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                if (annul_i) begin
                    state_nxt = IDLE;
                end else if (calc_last) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = annul_i ? IDLE : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_div_q <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        is_div_q <= in_div;
                        neg_a    <= in_neg_a;
                        neg_b    <= in_neg_b;
                        cnt      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, mag_a};
                        mplier   <= mag_b;
                        acc      <= '0;
                        rem      <= '0;
                        quo      <= mag_a;
                        dvsr     <= mag_b;
                        dbz_q    <= in_zero_div;
                        if (in_zero_div) begin
                            result_q <= {opdata1_i, {WIDTH{1'b1}}};
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (is_div_q) begin
                        rem <= rem_nxt;
                        quo <= {quo[WIDTH-2:0], q_bit};
                    end else begin
                        acc    <= acc_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                FIX: begin
                    if (!annul_i) begin
                        result_q <= fix_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o        = (state != IDLE);
    assign ready_o       = (state == DONE) && !annul_i;
    assign result_o      = result_q;
    assign div_by_zero_o = dbz_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32): directed and random ops scored
// against a plain-arithmetic reference model.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           resetn;
    logic           start_i;
    logic [1:0]     op_i;
    logic [W-1:0]   opdata1_i;
    logic [W-1:0]   opdata2_i;
    logic           annul_i;
    logic           busy_o;
    logic           ready_o;
    logic [2*W-1:0] result_o;
    logic           div_by_zero_o;
    mdu_state_e     state_dbg;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start_i       (start_i),
        .op_i          (op_i),
        .opdata1_i     (opdata1_i),
        .opdata2_i     (opdata2_i),
        .annul_i       (annul_i),
        .busy_o        (busy_o),
        .ready_o       (ready_o),
        .result_o      (result_o),
        .div_by_zero_o (div_by_zero_o),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int             n_cmp  = 0;
    int             n_fail = 0;
    logic [2*W-1:0] exp_q[$];
    logic           exp_dbz_q[$];
    logic [2*W-1:0] last_result;

    task automatic check64(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2*W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                  input logic [W-1:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op[1] && b == '0) return {a, {W{1'b1}}};
        case (op)
            2'b00:   return 64'(sa * sb);
            2'b01:   return ua * ub;
            2'b10: begin
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
            default: return {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] b);
`ifdef MDU_EARLY_OUT_EN
        logic [W-1:0] mag;
        int           n;
`endif
        if (op[1] && b == '0) return 1;
`ifdef MDU_EARLY_OUT_EN
        if (!op[1]) begin
            mag = (op == 2'b00 && b[W-1]) ? -b : b;
            n   = 1;
            for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
            return n + 2;
        end
`endif
        return W + 2;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; that cycle is cycle 0 of the request.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int             lat, k, busy_gaps;
        logic [2*W-1:0] exp;
        logic           exp_dbz;
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        exp_q.push_back(ref_result(op, a, b));
        exp_dbz_q.push_back(op[1] && (b == '0));
        lat = ref_latency(op, b);
        @(posedge clk);
        @(negedge clk);
        start_i   = 1'b0;
        k         = 1;
        busy_gaps = 0;
        if (lat > 1) begin
            check64("result_hold", result_o, last_result);
            check_int("dbz_cleared", int'(div_by_zero_o), 0);
        end
        while (!ready_o && k < 200) begin
            if (!busy_o) busy_gaps++;
            @(negedge clk);
            k++;
        end
        exp     = exp_q.pop_front();
        exp_dbz = exp_dbz_q.pop_front();
        check_int("latency", k, lat);
        check_int("busy_gaps", busy_gaps, 0);
        check64("result", result_o, exp);
        check_int("dbz", int'(div_by_zero_o), int'(exp_dbz));
        last_result = exp;
        @(negedge clk);
        check_int("ready_single", int'(ready_o), 0);
        check_int("idle_after", int'(busy_o), 0);
    endtask

    // Holds start_i high for cycles 0..39 and counts completions in cycles 1..40.
    task automatic hold_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int             lat, t, exp_pulses, accepts, pulses, k;
        logic [2*W-1:0] exp;
        lat        = ref_latency(op, b);
        exp        = ref_result(op, a, b);
        exp_pulses = 0;
        accepts    = 0;
        t          = 0;
        while (t <= 39) begin
            accepts++;
            if (t + lat <= 40) exp_pulses++;
            t += lat + 1;
        end
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        start_i   = 1'b1;
        pulses    = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o) begin
                pulses++;
                check64("hold_result", result_o, exp);
            end
        end
        start_i = 1'b0;
        check_int("hold_pulses", pulses, exp_pulses);
        if (accepts > exp_pulses) begin
            k = 0;
            while (!ready_o && k < 200) begin
                @(negedge clk);
                k++;
            end
            check_int("hold_drain", int'(ready_o), 1);
            check64("hold_drain_result", result_o, exp);
            @(negedge clk);
        end
        last_result = exp;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int             readies;
        logic [1:0]     rop;
        logic [W-1:0]   ra, rb;
        resetn      = 1'b0;
        start_i     = 1'b0;
        op_i        = 2'b00;
        opdata1_i   = '0;
        opdata2_i   = '0;
        annul_i     = 1'b0;
        last_result = '0;
        #1;
        check_int("rst_busy", int'(busy_o), 0);
        check_int("rst_ready", int'(ready_o), 0);
        check64("rst_result", result_o, '0);
        check_int("rst_dbz", int'(div_by_zero_o), 0);
        check_int("rst_state", int'(state_dbg), int'(IDLE));
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd5);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2);
        run_op(MDU_DIVU,  32'd7,         32'd2);
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op(MDU_DIVU,  32'd5,         32'd0);
        run_op(MDU_MULTU, 32'd2,         32'd3);
        run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000);
        run_op(MDU_DIV,   32'd7,         32'hFFFF_FFFE);
        run_op(MDU_MULT,  32'h1234_5678, 32'd0);

        // Annul mid-CALC: cycle 0 start, annul pulse in cycle 10.
        op_i      = MDU_DIVU;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        readies   = 0;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (ready_o) readies++;
            @(negedge clk);
        end
        annul_i = 1'b1;
        if (ready_o) readies++;
        @(negedge clk);
        annul_i = 1'b0;
        check_int("annul_busy", int'(busy_o), 0);
        check_int("annul_no_ready", readies + int'(ready_o), 0);
        check64("annul_result", result_o, last_result);
        @(negedge clk);
        run_op(MDU_DIVU, 32'd1000, 32'd7);

        // start together with annul in IDLE is ignored.
        start_i = 1'b1;
        annul_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        check_int("annul_start_idle", int'(busy_o), 0);
        @(negedge clk);

        // Random operations.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb);
        end

        // Asynchronous reset between clock edges during CALC.
        run_op(MDU_MULTU, 32'd9, 32'd9);
        op_i      = MDU_DIVU;
        opdata1_i = 32'd12345;
        opdata2_i = 32'd11;
        start_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check_int("areset_busy", int'(busy_o), 0);
        check_int("areset_ready", int'(ready_o), 0);
        check64("areset_result", result_o, '0);
        last_result = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        hold_start(MDU_DIVU, 32'd5, 32'd0);
        @(negedge clk);
        hold_start(MDU_DIVU, 32'd7, 32'd2);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
